mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, meaning: max BUSY cycles waiting for busAck before abort.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-low.
REQ-004 memReadM  in  1  load request from the memory-stage pipeline register.
REQ-005 memWriteM  in  1  store request from the memory-stage pipeline register.
REQ-006 sizeM  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 loadUnsignedM  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-008 aluOutM  in  32  byte address.
REQ-009 writeDataM  in  32  store data, right-justified.
REQ-010 busReq  out  1  bus request; held stable until busAck or abort.
REQ-011 busWe  out  1  1 = write transaction.
REQ-012 busAddr  out  32  word address, {aluOutM[31:2],2'b00}.
REQ-013 busWData  out  32  lane-replicated store data.
REQ-014 busBe  out  4  byte enables, lane0 = bits 7:0 (little-endian).
REQ-015 busAck  in  1  responder completion, one-cycle pulse; busRData valid with it.
REQ-016 busRData  in  32  read data.
REQ-017 stallM  out  1  freezes the pipeline while an access is outstanding.
REQ-018 readDataM  out  32  formatted load result toward writeback.
REQ-019 misalignM  out  1  one-cycle flag: misaligned access rejected.
REQ-020 timeoutM  out  1  one-cycle flag: access aborted after TIMEOUT_CYC.

Function
REQ-021 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-022 IDLE: request = memReadM|memWriteM; memWriteM wins if both asserted (read ignored).
REQ-023 Alignment: half requires addr[0]=0, word requires addr[1:0]=00, byte always aligned.
REQ-024 IDLE + aligned request: stallM=1 combinationally same cycle; latch busAddr, busWe, busBe, busWData, size, unsigned, addr[1:0]; next state BUSY.
REQ-025 IDLE + misaligned request: no bus transaction, no stall, misalignM=1 next cycle for one cycle, readDataM unchanged; remain IDLE.
REQ-026 BUSY: busReq=1, stallM=1, latched bus fields constant; cycle counter increments from 0.
REQ-027 BUSY + busAck: capture formatted busRData into readDataM (loads only; stores leave it unchanged); next state DONE; busReq=0 from DONE.
REQ-028 BUSY, counter reaches TIMEOUT_CYC-1 without busAck: readDataM=0, timeoutM=1 in DONE, next state DONE.
REQ-029 busAck in same cycle as timeout limit: ack wins, no timeoutM.
REQ-030 DONE: stallM=0 for exactly one cycle so the pipeline advances; next state IDLE unconditionally (total latency = bus wait + 2 cycles).
REQ-031 busAck outside BUSY is ignored.
REQ-032 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111.
REQ-033 Store data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-034 Load format: select lane by addr[1:0]/addr[1]; extend to 32 bits per loadUnsignedM; word passes through.

Reset
REQ-035 RST low at any edge: state IDLE, counter 0, busReq 0, busWe 0, busAddr 0, busWData 0, busBe 0, readDataM 0, misalignM 0, timeoutM 0.
REQ-036 Reset mid-BUSY aborts the transaction: busReq low from the next cycle, no flag raised.
REQ-037 stallM is 0 while RST low.

Structure
REQ-038 Shared package pipe_mem_pkg holds size encodings (SZ_WORD/SZ_HALF/SZ_BYTE) and the FSM state enum.
REQ-039 One combinational sub-module mem_lane_fmt: byte-enable/store replication and load extraction/extension.

Verification
REQ-040 Word store addr 0x100, data 0xDEADBEEF, busAck 3 cycles after busReq -> busBe 1111, busAddr 0x100, stallM high 4 cycles, one DONE cycle.
REQ-041 Byte load addr 0x203, busRData 0x80FF_1234, signed -> readDataM 0xFFFFFF80; unsigned -> 0x00000080.
REQ-042 Half store addr 0x12, data 0x0000ABCD -> busBe 1100, busWData 0xABCDABCD.
REQ-043 Word load addr 0x102 -> misalignM one cycle, busReq never high, stallM 0.
REQ-044 No busAck, TIMEOUT_CYC=8 -> busReq high 8 cycles, timeoutM one pulse, readDataM 0, return IDLE.
REQ-045 RST low on 2nd BUSY cycle -> busReq 0 next cycle, all outputs at reset values, late busAck ignored.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared size encodings, FSM states and alignment helper for the memory stage
package pipe_mem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    // size 2'b11 falls into the word branch, so it is checked like a word
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_BYTE) ? 1'b1 : (size == SZ_HALF) ? ~lo[0] : (lo == 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte lane steering for stores and lane extraction/extension for loads
//   i_size      access size (SZ_WORD/SZ_HALF/SZ_BYTE, 2'b11 acts as word)
//   i_addr_lo   byte offset within the word
//   i_unsigned  1 = zero-extend sub-word loads, 0 = sign-extend
//   i_wdata     right-justified store data
//   i_rdata     raw bus read word
//   o_be        byte enables, bit 0 = bits 7:0
//   o_wdata     lane-replicated store data
//   o_rdata     formatted load result
module mem_lane_fmt
    import pipe_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_be    = (i_size == SZ_BYTE) ? (4'b0001 << i_addr_lo) :
                  (i_size == SZ_HALF) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} :
                  (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = (i_size == SZ_BYTE) ? {{24{~i_unsigned & w_byte[7]}}, w_byte} :
                  (i_size == SZ_HALF) ? {{16{~i_unsigned & w_half[15]}}, w_half} : i_rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer between the pipeline and a req/ack bus
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_mem_read_m/_write_m  load/store request (store wins when both set)
//   i_size_m, i_load_unsigned_m, i_alu_out_m, i_write_data_m   access description
//   o_bus_req/_we/_addr/_wdata/_be, i_bus_ack, i_bus_rdata      bus transaction
//   o_stall_m              holds the pipeline while an access is outstanding
//   o_read_data_m          formatted load result
//   o_misalign_m, o_timeout_m   one-cycle error flags
module mem_access_unit
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read_m,
    input  logic        i_mem_write_m,
    input  logic [1:0]  i_size_m,
    input  logic        i_load_unsigned_m,
    input  logic [31:0] i_alu_out_m,
    input  logic [31:0] i_write_data_m,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall_m,
    output logic [31:0] o_read_data_m,
    output logic        o_misalign_m,
    output logic        o_timeout_m
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_read_data;
    logic        r_misalign;
    logic        r_timeout;

    logic        w_req;
    logic        w_aligned;
    logic [1:0]  w_size;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_req     = i_mem_read_m | i_mem_write_m;
    assign w_aligned = is_aligned(i_size_m, i_alu_out_m[1:0]);
    // In IDLE the formatter steers the incoming store; otherwise it decodes the pending load.
    assign w_size    = (r_state == ST_IDLE) ? i_size_m : r_size;
    assign w_addr_lo = (r_state == ST_IDLE) ? i_alu_out_m[1:0] : r_addr_lo;

    mem_lane_fmt u_fmt (
        .i_size     (w_size),
        .i_addr_lo  (w_addr_lo),
        .i_unsigned (r_unsigned),
        .i_wdata    (i_write_data_m),
        .i_rdata    (i_bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_size      <= SZ_WORD;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= '0;
            r_read_data <= '0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_aligned) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_write_m;
                        r_bus_addr  <= {i_alu_out_m[31:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_be    <= w_be;
                        r_size      <= i_size_m;
                        r_unsigned  <= i_load_unsigned_m;
                        r_addr_lo   <= i_alu_out_m[1:0];
                        r_cnt       <= '0;
                        r_state     <= ST_BUSY;
                    end else if (w_req) begin
                        r_misalign <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // ack is tested first so an ack on the last allowed cycle still completes
                    if (i_bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we)
                            r_read_data <= w_load;
                        r_state <= ST_DONE;
                    end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_bus_req   <= 1'b0;
                        r_read_data <= '0;
                        r_timeout   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // stall rises in the request cycle itself so the pipeline never moves past an accepted access
    assign o_stall_m     = i_rst_n && (((r_state == ST_IDLE) && w_req && w_aligned) || (r_state == ST_BUSY));
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_be      = r_bus_be;
    assign o_read_data_m = r_read_data;
    assign o_misalign_m  = r_misalign;
    assign o_timeout_m   = r_timeout;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus multi-cycle sequences for mem_access_unit
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n, mem_read, mem_write, uns, bus_ack;
    logic [1:0]  size;
    logic [31:0] addr, wd, bus_rdata;
    logic        bus_req, bus_we, stall, misalign, timeout;
    logic [31:0] bus_addr, bus_wdata, read_data;
    logic [3:0]  bus_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYC(8)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_mem_read_m      (mem_read),
        .i_mem_write_m     (mem_write),
        .i_size_m          (size),
        .i_load_unsigned_m (uns),
        .i_alu_out_m       (addr),
        .i_write_data_m    (wd),
        .o_bus_req         (bus_req),
        .o_bus_we          (bus_we),
        .o_bus_addr        (bus_addr),
        .o_bus_wdata       (bus_wdata),
        .o_bus_be          (bus_be),
        .i_bus_ack         (bus_ack),
        .i_bus_rdata       (bus_rdata),
        .o_stall_m         (stall),
        .o_read_data_m     (read_data),
        .o_misalign_m      (misalign),
        .o_timeout_m       (timeout)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd_exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; size = v.sz; uns = v.un; addr = v.a; wd = v.d;
        #1;
        chk($sformatf("v%0d stall_req", idx), 32'(stall), 32'(!v.mis));
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        if (!v.mis) begin
            chk($sformatf("v%0d bus_req", idx), 32'(bus_req), 32'd1);
            chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.wr));
            chk($sformatf("v%0d bus_addr", idx), bus_addr, v.a & 32'hFFFF_FFFC);
            chk($sformatf("v%0d bus_be", idx), 32'(bus_be), 32'(v.be));
            if (v.wr)
                chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
            chk($sformatf("v%0d stall_busy", idx), 32'(stall), 32'd1);
            bus_ack = 1'b1; bus_rdata = v.rdata;
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            chk($sformatf("v%0d done_stall", idx), 32'(stall), 32'd0);
            chk($sformatf("v%0d done_req", idx), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d read_data", idx), read_data, v.rd_exp);
            chk($sformatf("v%0d timeout", idx), 32'(timeout), 32'd0);
        end else begin
            chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'd1);
            chk($sformatf("v%0d mis_req", idx), 32'(bus_req), 32'd0);
            chk($sformatf("v%0d mis_stall", idx), 32'(stall), 32'd0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d misalign_clr", idx), 32'(misalign), 32'd0);
            chk($sformatf("v%0d mis_read_data", idx), read_data, v.rd_exp);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  stall_pat, req_pat;
        int          br, tc, sc, tpos;
        logic [31:0] rd_at;

        vecs[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 4'h8, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 4'h8, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h012, 32'h0000ABCD, 32'h0,        1'b0, 4'hC, 32'hABCDABCD, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h002, 32'h0,        32'h80017FFE, 1'b0, 4'hC, 32'h0,        32'hFFFF_8001};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h000, 32'h0,        32'h80017FFE, 1'b0, 4'h3, 32'h0,        32'h0000_7FFE};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h002, 32'h0,        32'h80017FFE, 1'b0, 4'hC, 32'h0,        32'h0000_8001};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h001, 32'h0,        32'h00009A00, 1'b0, 4'h2, 32'h0,        32'hFFFF_FF9A};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h002, 32'h123456C3, 32'h0,        1'b0, 4'h4, 32'hC3C3C3C3, 32'hFFFF_FF9A};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h040, 32'h0,        32'hCAFEF00D, 1'b0, 4'hF, 32'h0,        32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h080, 32'h11223344, 32'hFFFFFFFF, 1'b0, 4'hF, 32'h11223344, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hCAFE_F00D};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h003, 32'h5555AAAA, 32'h0,        1'b1, 4'h0, 32'h0,        32'hCAFE_F00D};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h5555AAAA, 32'h0,        1'b1, 4'h0, 32'h0,        32'hCAFE_F00D};
        vecs[14] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h0000007F, 1'b0, 4'h1, 32'h0,        32'h0000_007F};

        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wd = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            apply(vecs[i], i);

        // word store with ack on the third bus cycle
        addr = 32'h100; wd = 32'hDEADBEEF; size = 2'b00; stall_pat = '0; req_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_write = (i == 0); bus_ack = (i == 3);
            #1;
            stall_pat[i] = stall; req_pat[i] = bus_req;
            if (i == 1) begin
                chk("ack3_bus_be", 32'(bus_be), 32'hF);
                chk("ack3_bus_addr", bus_addr, 32'h100);
            end
        end
        bus_ack = 1'b0;
        chk("ack3_stall_pattern", 32'(stall_pat), 32'b001111);
        chk("ack3_req_pattern", 32'(req_pat), 32'b001110);
        chk("ack3_read_data_kept", read_data, 32'h0000_007F);

        // load that never gets an ack: expires after 8 bus cycles
        addr = 32'h300; size = 2'b00; br = 0; tc = 0; sc = 0; tpos = -1; rd_at = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_read = (i == 0);
            #1;
            br += int'(bus_req); tc += int'(timeout); sc += int'(stall);
            if (timeout) begin tpos = i; rd_at = read_data; end
        end
        chk("to_req_cycles", 32'(br), 32'd8);
        chk("to_pulses", 32'(tc), 32'd1);
        chk("to_position", 32'(tpos), 32'd9);
        chk("to_stall_cycles", 32'(sc), 32'd9);
        chk("to_read_data", rd_at, 32'd0);

        // ack arriving on the last allowed cycle completes normally
        addr = 32'h500; bus_rdata = 32'h5A5A5A5A; br = 0; tc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_read = (i == 0); bus_ack = (i == 8);
            #1;
            br += int'(bus_req); tc += int'(timeout);
        end
        bus_ack = 1'b0;
        chk("lim_req_cycles", 32'(br), 32'd8);
        chk("lim_no_timeout", 32'(tc), 32'd0);
        chk("lim_read_data", read_data, 32'h5A5A5A5A);

        // stray ack while idle
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("idle_ack_read_data", read_data, 32'h5A5A5A5A);
        chk("idle_ack_req", 32'(bus_req), 32'd0);
        chk("idle_ack_stall", 32'(stall), 32'd0);

        // reset during the second bus cycle, then a late ack
        addr = 32'h400; wd = 32'h0BADF00D;
        @(negedge clk);
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        chk("rb_req_first", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rb_stall_in_reset", 32'(stall), 32'd0);
        @(negedge clk);
        #1;
        chk("rb_req", 32'(bus_req), 32'd0);
        chk("rb_we", 32'(bus_we), 32'd0);
        chk("rb_addr", bus_addr, 32'd0);
        chk("rb_wdata", bus_wdata, 32'd0);
        chk("rb_be", 32'(bus_be), 32'd0);
        chk("rb_read_data", read_data, 32'd0);
        chk("rb_flags", {30'd0, misalign, timeout}, 32'd0);
        rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        chk("rb_late_ack_data", read_data, 32'd0);
        chk("rb_late_ack_req", 32'(bus_req), 32'd0);
        chk("rb_late_ack_stall", 32'(stall), 32'd0);
        chk("rb_late_ack_timeout", 32'(timeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
